// File: rtl/gato_pkg.sv
// Shared encodings for the tic-tac-toe board controller and verifier.
package gato_pkg;

   localparam logic [1:0] CELDA_VACIA = 2'b00;
   localparam logic [1:0] CELDA_J1    = 2'b11;
   localparam logic [1:0] CELDA_J2    = 2'b01;

   localparam int MAX_JUGADAS = 9;

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      ESCRIBE  = 2'd1,
      VERIFICA = 2'd2,
      FIN      = 2'd3
   } estado_t;

endpackage

// File: rtl/tablero_gato_regs.sv
// 9x2-bit board register file with position decode and occupied lookup.
module tablero_gato_regs
   import gato_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            limpia,
   input  logic            escribe,
   input  logic [3:0]      posicion,
   input  logic [1:0]      marca,
   output logic [8:0][1:0] celdas,
   output logic            pos_ok,
   output logic            ocupada
);

   assign pos_ok = (posicion >= 4'd1) && (posicion <= 4'd9);

   always_comb begin
      ocupada = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (posicion == 4'(i + 1) && celdas[i] != CELDA_VACIA)
            ocupada = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         celdas <= '0;
      end else if (limpia) begin
         celdas <= '0;
      end else if (escribe) begin
         for (int i = 0; i < 9; i++) begin
            if (posicion == 4'(i + 1))
               celdas[i] <= marca;
         end
      end
   end

endmodule

// File: rtl/controlador_tablero_gato.sv
// Tic-tac-toe board/turn controller: validates moves, writes marks,
// strobes the verifier and freezes the game on a win or full board.
module controlador_tablero_gato
   import gato_pkg::*;
#(
   parameter int NUM_CELDAS = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       reinicia_juego,
   input  logic       jugada_valida,
   input  logic [3:0] posicion,
   input  logic       fin_juego,
   output logic [1:0] reg_c1,
   output logic [1:0] reg_c2,
   output logic [1:0] reg_c3,
   output logic [1:0] reg_c4,
   output logic [1:0] reg_c5,
   output logic [1:0] reg_c6,
   output logic [1:0] reg_c7,
   output logic [1:0] reg_c8,
   output logic [1:0] reg_c9,
   output logic       verifica_status,
   output logic       turno,
   output logic       jugada_rechazada,
   output logic       juego_terminado,
   output logic [$clog2(NUM_CELDAS+1)-1:0] num_jugadas
);

   localparam int W = $clog2(NUM_CELDAS + 1);

   estado_t        estado, estado_sig;
   logic [8:0][1:0] celdas;
   logic           pos_ok, ocupada;
   logic           acepta, rechaza, alterna;
   logic [1:0]     marca;

   assign marca = turno ? CELDA_J2 : CELDA_J1;

   tablero_gato_regs u_regs (
      .clk      (clk),
      .reset    (reset),
      .limpia   (reinicia_juego),
      .escribe  (acepta),
      .posicion (posicion),
      .marca    (marca),
      .celdas   (celdas),
      .pos_ok   (pos_ok),
      .ocupada  (ocupada)
   );

   always_comb begin
      estado_sig = estado;
      acepta     = 1'b0;
      rechaza    = 1'b0;
      alterna    = 1'b0;
      case (estado)
         ESPERA: begin
            if (jugada_valida) begin
               if (pos_ok && !ocupada) begin
                  acepta     = 1'b1;
                  estado_sig = ESCRIBE;
               end else begin
                  rechaza = 1'b1;
               end
            end
         end
         ESCRIBE: estado_sig = VERIFICA;
         VERIFICA: begin
            if (fin_juego || num_jugadas == W'(MAX_JUGADAS)) begin
               estado_sig = FIN;
            end else begin
               estado_sig = ESPERA;
               alterna    = 1'b1;
            end
         end
         FIN: rechaza = jugada_valida;
         default: estado_sig = ESPERA;
      endcase
      // a restart overrides any move decided on the same edge
      if (reinicia_juego) begin
         estado_sig = ESPERA;
         acepta     = 1'b0;
         rechaza    = 1'b0;
         alterna    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado           <= ESPERA;
         turno            <= 1'b0;
         num_jugadas      <= '0;
         jugada_rechazada <= 1'b0;
      end else begin
         estado           <= estado_sig;
         jugada_rechazada <= rechaza;
         if (reinicia_juego)
            turno <= 1'b0;
         else if (alterna)
            turno <= ~turno;
         if (reinicia_juego)
            num_jugadas <= '0;
         else if (acepta && num_jugadas < W'(MAX_JUGADAS))
            num_jugadas <= num_jugadas + 1'b1;
      end
   end

   assign verifica_status = (estado == VERIFICA);
   assign juego_terminado = (estado == FIN);

   assign reg_c1 = celdas[0];
   assign reg_c2 = celdas[1];
   assign reg_c3 = celdas[2];
   assign reg_c4 = celdas[3];
   assign reg_c5 = celdas[4];
   assign reg_c6 = celdas[5];
   assign reg_c7 = celdas[6];
   assign reg_c8 = celdas[7];
   assign reg_c9 = celdas[8];

endmodule
